// File: rtl/timer_programmable_pkg.sv
// Shared encodings for the programmable timer: FSM state codes and run-mode constants.
package timer_pkg;

    typedef logic [1:0] timer_state_t;

    localparam timer_state_t ST_IDLE    = 2'd0;
    localparam timer_state_t ST_RUN     = 2'd1;
    localparam timer_state_t ST_EXPIRED = 2'd2;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Debug view of the control FSM, handy for binding checkers.
    typedef struct packed {
        timer_state_t state;
        logic         mode;
    } timer_status_t;

    function automatic int presc_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/timer_programmable_prescaler.sv
// Divides enabled clk cycles down to one tick every PRESCALE enabled cycles.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int W = presc_width(PRESCALE);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // With PRESCALE = 1 the counter is stuck at 0, so tick reduces to en.
    assign tick = en && !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_programmable.sv
// Runtime-programmable tick/timeout timer: counts prescaled ticks 0..final, pulses done
// at each expiry; periodic or one-shot, with start/stop/pause and a loadable final value.
module timer_programmable
    import timer_pkg::*;
#(
    parameter int BITS          = 16,
    parameter int PRESCALE      = 1,
    parameter int DEFAULT_FINAL = 49999
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            load,
    input  logic [BITS-1:0] final_in,
    input  logic            mode,
    input  logic            start,
    input  logic            stop,
    output logic [BITS-1:0] count,
    output logic            done,
    output logic            running,
    output logic            expired
);

    timer_state_t    state_q, state_d;
    logic [BITS-1:0] count_q, count_d;
    logic [BITS-1:0] final_q, final_d;
    logic            mode_q, mode_d;
    logic            done_q, done_d;
    logic            running_q, expired_q;
    logic            tick;
    logic            presc_clear;
    logic            presc_en;
    timer_status_t   status;

    assign status = '{state: state_q, mode: mode_q};

    // Any start or stop restarts the prescaler phase; it only advances while running.
    assign presc_clear = stop || start;
    assign presc_en    = en && (state_q == ST_RUN);

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (presc_clear),
        .en    (presc_en),
        .tick  (tick)
    );

    // Command priority: stop > start > load > counting (rst handled in the register block).
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        final_d = final_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_RUN;
            count_d = '0;
            mode_d  = mode;
        end else if (load && (state_q != ST_RUN)) begin
            final_d = final_in;
        end else if ((state_q == ST_RUN) && tick) begin
            if (count_q == final_q) begin
                done_d = 1'b1;
                if (mode_q == MODE_ONESHOT) begin
                    state_d = ST_EXPIRED;
                end else begin
                    count_d = '0;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            final_q   <= BITS'(DEFAULT_FINAL);
            mode_q    <= MODE_PERIODIC;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            final_q   <= final_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_EXPIRED);
        end
    end

    assign count   = count_q;
    assign done    = done_q;
    assign running = running_q;
    assign expired = expired_q;

endmodule

// File: doc/timer_programmable.md
Name: timer_programmable

Overview:
Runtime-programmable successor to the fixed-FINAL_VALUE timer.
- Counts prescaled ticks from 0 up to a loadable final value.
- Emits a one-cycle done pulse at each expiry.
- Supports periodic and one-shot modes, with start, stop and pause (en).
- Used as the general tick/timeout source for display refresh, debounce and baud-style timing in the design.

Parameters:
- BITS, 16: width of the count and final-value registers.
- PRESCALE, 1: clk cycles per count tick. Must be ≥1. Prescaler width is max(1, $clog2(PRESCALE)).
- DEFAULT_FINAL, 49999: reset value of the final register. Must be < 2^BITS.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: count enable. 0 pauses the prescaler and count while running.
- load, input, 1: write final_in into the final register.
- final_in, input, BITS: new final value.
- mode, input, 1: 0 = periodic, 1 = one-shot. Sampled on start.
- start, input, 1: begin or restart a timing run.
- stop, input, 1: abort the run and freeze count.
- count, output, BITS: current tick count.
- done, output, 1: registered one-cycle pulse on expiry.
- running, output, 1: high in RUN.
- expired, output, 1: sticky; high in EXPIRED (one-shot finished).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates on the rising clk edge.
- Reset values: state = IDLE, count = 0, prescaler = 0, final_reg = DEFAULT_FINAL, mode_reg = 0, done = 0, running = 0, expired = 0.
- rst has priority over every other input. Reset mid-run aborts with no done pulse.
- States: IDLE, RUN, EXPIRED.
- Command priority within a cycle: rst > stop > start > load > counting.
- load:
  - Accepted only in IDLE or EXPIRED. final_reg = final_in after the edge.
  - Ignored in RUN; the running compare value never changes mid-run.
  - If load and start arrive in the same cycle outside RUN, start wins; load is discarded.
- start, from any state:
  - count = 0, prescaler = 0, mode_reg = mode, expired = 0, state = RUN.
  - start in RUN restarts the run and resamples mode.
- stop:
  - state = IDLE, count holds its value for readback, prescaler = 0, no done pulse.
  - stop together with start: stop wins.
- RUN with en = 0: count and prescaler hold. done stays 0.
- RUN with en = 1:
  - Prescaler increments each cycle. tick = (prescaler == PRESCALE-1); on tick the prescaler returns to 0.
  - With PRESCALE = 1, tick is asserted every en cycle.
- On tick:
  - If count != final_reg: count = count + 1.
  - If count == final_reg: done = 1 for the next cycle only.
    - Periodic: count = 0, stay in RUN.
    - One-shot: count holds at final_reg, state = EXPIRED, expired = 1.
- done is 0 in every cycle not described above. It is never asserted for two consecutive cycles unless final_reg = 0 and PRESCALE = 1.
- Timing with PRESCALE = 1, en = 1, start sampled at edge 0:
  - count reaches F after edge F.
  - done is high between edges F+1 and F+2, with count = 0 (periodic).
  - Periodic expiry period is (F+1)*PRESCALE enabled cycles.
- final_reg = 0: done on every tick. With PRESCALE = 1, done is continuously high while en = 1.
- final_reg = 2^BITS-1: count reaches all-ones and returns to 0 with no overflow side effects.
- Arithmetic is unsigned. The count never exceeds final_reg.
- running = (state == RUN). expired = (state == EXPIRED). Both are registered.

Decomposition:
- Package timer_pkg holds:
  - state encoding (IDLE = 2'd0, RUN = 2'd1, EXPIRED = 2'd2);
  - mode constants MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1.
- Sub-module timer_prescaler (parameter PRESCALE; ports clk, rst, clear, en; output tick) generates the tick.
  - It is instantiated once.
  - When PRESCALE = 1, it reduces to tick = en.

Test Plan:
1. Reset defaults: hold rst 3 cycles -> count = 0, done = 0, running = 0, expired = 0. Then start with mode = 0, en = 1, PRESCALE = 1 -> first done exactly 50000 cycles after the start edge (DEFAULT_FINAL = 49999).
2. Periodic, load F = 4, PRESCALE = 1 -> count sequence 0,1,2,3,4,0,…; done pulses every 5 cycles, each one cycle wide, coincident with count = 0.
3. One-shot, F = 3, PRESCALE = 4 -> done once 16 cycles after start, then expired = 1, running = 0, count stays 3. A second start clears expired and repeats the run.
4. Pause and stop, F = 9, PRESCALE = 1: en low for 7 cycles at count = 5 -> count holds 5 and done is delayed by 7 cycles. Then stop at count = 8 -> IDLE, count = 8, no done.
5. Collisions:
   - load F = 2 during RUN -> ignored; F stays 4.
   - stop and start in the same cycle -> IDLE.
   - start during RUN at count = 3 -> count = 0 next cycle.
   - rst asserted with done pending -> done = 0 and all outputs at reset values.
6. Edge values:
   - F = 0, PRESCALE = 1 -> done high every cycle while en = 1.
   - BITS = 4, F = 15 -> count wraps 15 → 0 with done = 1.
